// File: rtl/arm_lp_pkg.sv
// Shared defaults and the operand bundle passed from operand preparation to the ALU stage.
package arm_lp_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned IMM_W_DEF    = 26;
    localparam int unsigned ZERO_REG_DEF = 31;

    // Operand set as seen by the ALU stage at default widths.
    typedef struct packed {
        logic                  valid;
        logic [DATA_W_DEF-1:0] op1;
        logic [DATA_W_DEF-1:0] op2;
        logic [DATA_W_DEF-1:0] offset;
    } operand_bundle_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with a hard-wired zero register.
// Same-cycle write forwarding is enabled by defining OPPREP_BYPASS_EN.
module regfile_2r1w
    import arm_lp_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1_c,
    output logic [DATA_W-1:0] rdata2_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok_c;

    assign wr_ok_c = we && (waddr != ZERO_ADDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok_c) begin
            regs[waddr] <= wdata;
        end
    end

    // Zero masking is applied last so it also wins over forwarding.
    always_comb begin
        rdata1_c = regs[raddr1];
        rdata2_c = regs[raddr2];
`ifdef OPPREP_BYPASS_EN
        if (wr_ok_c && (waddr == raddr1)) rdata1_c = wdata;
        if (wr_ok_c && (waddr == raddr2)) rdata2_c = wdata;
`endif
        if (raddr1 == ZERO_ADDR) rdata1_c = '0;
        if (raddr2 == ZERO_ADDR) rdata2_c = '0;
    end

endmodule

// File: rtl/operand_prep_stage.sv
// Operand preparation: register read, offset extension, ALU-source mux, valid/stall register.
// Optional same-cycle write forwarding: define OPPREP_BYPASS_EN.
module operand_prep_stage
    import arm_lp_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned IMM_W    = IMM_W_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inValid,
    input  logic              stall,
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    input  logic              aluSRC,
    input  logic              immSigned,
    input  logic [IMM_W-1:0]  pcOffsetOrig,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeRegister,
    input  logic [DATA_W-1:0] writeData,
    output logic              outValid,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] pcOffsetFilled
);

    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;
    logic [DATA_W-1:0] ext_c;
    logic [DATA_W-1:0] op2_c;

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we       (regWrite),
        .waddr    (writeRegister),
        .wdata    (writeData),
        .raddr1   (reg1),
        .raddr2   (reg2),
        .rdata1_c (rd1_c),
        .rdata2_c (rd2_c)
    );

    // A sized cast of a signed value sign-extends; equal widths pass through unchanged.
    always_comb begin
        ext_c = DATA_W'(pcOffsetOrig);
        if (immSigned) ext_c = DATA_W'($signed(pcOffsetOrig));
        op2_c = aluSRC ? ext_c : rd2_c;
    end

    // Data outputs only move on a valid capture; a bubble clears just the valid bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            outValid       <= 1'b0;
            readData1      <= '0;
            readData2      <= '0;
            pcOffsetFilled <= '0;
        end else if (!stall) begin
            outValid <= inValid;
            if (inValid) begin
                readData1      <= rd1_c;
                readData2      <= op2_c;
                pcOffsetFilled <= ext_c;
            end
        end
    end

endmodule

// File: tb/tb_operand_prep_stage.sv
// Directed, table-driven bench for operand_prep_stage (default widths).
module tb_operand_prep_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        stall;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic        aluSRC;
    logic        immSigned;
    logic [25:0] pcOffsetOrig;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        outValid;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] pcOffsetFilled;

    int checks = 0;
    int errors = 0;

`ifdef OPPREP_BYPASS_EN
    localparam logic [31:0] BYP_R7  = 32'hA5A5_A5A5;
    localparam logic [31:0] BYP_R5  = 32'h1111_1111;
`else
    localparam logic [31:0] BYP_R7  = 32'h0000_0000;
    localparam logic [31:0] BYP_R5  = 32'hDEAD_BEEF;
`endif

    operand_prep_stage dut (
        .clock          (clock),
        .reset          (reset),
        .inValid        (inValid),
        .stall          (stall),
        .reg1           (reg1),
        .reg2           (reg2),
        .aluSRC         (aluSRC),
        .immSigned      (immSigned),
        .pcOffsetOrig   (pcOffsetOrig),
        .regWrite       (regWrite),
        .writeRegister  (writeRegister),
        .writeData      (writeData),
        .outValid       (outValid),
        .readData1      (readData1),
        .readData2      (readData2),
        .pcOffsetFilled (pcOffsetFilled)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic        st;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        alu;
        logic        sgn;
        logic [25:0] off;
        logic        e_v;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_off;
    } vec_t;

    vec_t vecs [14];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic st, input logic [4:0] r1,
                         input logic [4:0] r2, input logic alu, input logic sgn,
                         input logic [25:0] off);
        regWrite      = we;
        writeRegister = wa;
        writeData     = wd;
        inValid       = iv;
        stall         = st;
        reg1          = r1;
        reg2          = r2;
        aluSRC        = alu;
        immSigned     = sgn;
        pcOffsetOrig  = off;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] of);
        cmp({tag, ".valid"}, {31'd0, outValid}, {31'd0, v});
        cmp({tag, ".rd1"}, readData1, d1);
        cmp({tag, ".rd2"}, readData2, d2);
        cmp({tag, ".off"}, pcOffsetFilled, of);
    endtask

    initial begin
        //            we   wa     wd             iv   st   r1     r2     alu  sgn  off            e_v  e_rd1          e_rd2          e_off
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0,         32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd5,  5'd0,  1'b0, 1'b0, 26'h0,       1'b1, 32'hDEADBEEF,  32'h0,         32'h0};
        vecs[2]  = '{1'b1, 5'd31, 32'h12345678, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 26'h0,       1'b0, 32'hDEADBEEF,  32'h0,         32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd31, 5'd31, 1'b0, 1'b0, 26'h0,       1'b1, 32'h0,         32'h0,         32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 1'b0, 5'd5,  5'd7,  1'b0, 1'b0, 26'h0,       1'b1, 32'hDEADBEEF,  BYP_R7,        32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  5'd7,  1'b0, 1'b0, 26'h0,       1'b1, 32'h0,         32'hA5A5A5A5,  32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd7,  5'd5,  1'b1, 1'b1, 26'h3FFFFFC, 1'b1, 32'hA5A5A5A5,  32'hFFFFFFFC,  32'hFFFFFFFC};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd7,  5'd5,  1'b1, 1'b0, 26'h3FFFFFC, 1'b1, 32'hA5A5A5A5,  32'h03FFFFFC,  32'h03FFFFFC};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  5'd5,  1'b0, 1'b1, 26'h1FFFFFF, 1'b1, 32'h0,         32'hDEADBEEF,  32'h01FFFFFF};
        vecs[9]  = '{1'b1, 5'd5,  32'h11111111, 1'b1, 1'b0, 5'd5,  5'd5,  1'b0, 1'b0, 26'h0,       1'b1, BYP_R5,        BYP_R5,        32'h0};
        vecs[10] = '{1'b1, 5'd31, 32'h77777777, 1'b1, 1'b0, 5'd31, 5'd0,  1'b0, 1'b0, 26'h123,     1'b1, 32'h0,         32'h0,         32'h00000123};
        vecs[11] = '{1'b1, 5'd0,  32'hCAFEF00D, 1'b1, 1'b1, 5'd5,  5'd7,  1'b1, 1'b1, 26'h2AAAAAA, 1'b1, 32'h0,         32'h0,         32'h00000123};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 26'h0,       1'b1, 32'hCAFEF00D,  32'hCAFEF00D,  32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd9,  5'd9,  1'b1, 1'b1, 26'h3FFFFFF, 1'b0, 32'hCAFEF00D,  32'hCAFEF00D,  32'h0};

        // Reset held two cycles with a valid instruction presented.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b0, 1'b0, 26'h0);
        reset = 1'b1;
        tick();
        check_all("reset0", 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        cmp("reset1.valid", {31'd0, outValid}, 32'd0);
        reset = 1'b0;

        // Every register reads back as zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'(i), 5'(31 - i), 1'b0, 1'b0, 26'h0);
            tick();
            cmp($sformatf("rst_rd1[%0d]", i), readData1, 32'h0);
            cmp($sformatf("rst_rd2[%0d]", 31 - i), readData2, 32'h0);
        end
        cmp("rst_scan.valid", {31'd0, outValid}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iv, vecs[i].st,
                  vecs[i].r1, vecs[i].r2, vecs[i].alu, vecs[i].sgn, vecs[i].off);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_rd1,
                      vecs[i].e_rd2, vecs[i].e_off);
        end

        // Capture a set, then stall three cycles with changing inputs and writes.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 5'd7, 1'b0, 1'b1, 26'h2000000);
        tick();
        check_all("cap", 1'b1, 32'h11111111, 32'hA5A5A5A5, 32'hFE000000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(9 + i), 32'h5000_0000 + 32'(i), 1'(i & 1), 1'b1,
                  5'(9 + i), 5'd0, 1'(i & 1), 1'b0, 26'(i + 1));
            tick();
            check_all($sformatf("stall%0d", i), 1'b1, 32'h11111111, 32'hA5A5A5A5, 32'hFE000000);
        end

        // Reset wins over stall, capture and write.
        drive(1'b1, 5'd5, 32'hFFFF0000, 1'b1, 1'b1, 5'd5, 5'd9, 1'b1, 1'b1, 26'h3FFFFFF);
        reset = 1'b1;
        tick();
        check_all("rst_stall", 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;

        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 5'd9, 1'b0, 1'b0, 26'h0);
        tick();
        check_all("post_rst", 1'b1, 32'h0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_prep_stage.md
Name: operand_prep_stage

Overview:
- Parametrised successor to the original operand-preparation stage.
- Holds the architectural register file (2 read ports, 1 write port) and applies the ALU-source mux.
- Sign- or zero-extends the PC/immediate offset to the datapath width.
- Registers all operands into a valid/stall pipeline register feeding the ALU stage.
- Adds a hard-wired zero register, same-cycle write bypass, and stall hold.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- IMM_W, 26, width of the raw offset field; must be <= DATA_W.
- ZERO_REG, 31, register index that always reads 0 and ignores writes.

Ports:
- clock  in  1  main clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- inValid  in  1  decode stage presents a valid instruction.
- stall  in  1  downstream stall; hold pipeline register.
- reg1  in  ADDR_W  first source register address.
- reg2  in  ADDR_W  second source register address.
- aluSRC  in  1  0: readData2 = reg2 data; 1: readData2 = extended offset.
- immSigned  in  1  1: sign-extend pcOffsetOrig; 0: zero-extend.
- pcOffsetOrig  in  IMM_W  raw offset field.
- regWrite  in  1  write writeData to writeRegister.
- writeRegister  in  ADDR_W  write address.
- writeData  in  DATA_W  write data.
- outValid  out  1  pipeline register holds a valid operand set.
- readData1  out  DATA_W  registered reg1 operand.
- readData2  out  DATA_W  registered second operand (reg2 data or offset).
- pcOffsetFilled  out  DATA_W  registered extended offset.

Behaviour:
- Reset: all registers cleared to 0. outValid, readData1, readData2 and pcOffsetFilled are all 0 on the cycle after reset is sampled high.
- Reset priority: reset overrides a write, a capture and a stall in the same cycle.
- Write: at posedge, if regWrite && writeRegister != ZERO_REG, the register takes writeData. Writes proceed regardless of stall or inValid.
- Read: combinational array read of reg1/reg2.
  - ZERO_REG reads as 0 unconditionally, including when bypassed.
- Bypass (see Optional Feature): if regWrite && writeRegister == regN && regN != ZERO_REG, the regN operand takes writeData in the same cycle. Both ports may bypass simultaneously.
- Extension: ext = immSigned ? sign-extend(pcOffsetOrig) : zero-extend(pcOffsetOrig), to DATA_W. When IMM_W == DATA_W, ext = pcOffsetOrig.
- Operand 2: op2 = aluSRC ? ext : reg2 operand.
- Pipeline register, one-cycle latency from inputs to outputs:
  - stall = 1: all outputs hold, including outValid.
  - stall = 0 and inValid = 1: capture op1, op2 and ext; outValid <= 1.
  - stall = 0 and inValid = 0: outValid <= 0; data outputs hold their last values.
- Stall does not block writes. A write landing during a stall is not reflected in the held operands; the consumer handles that hazard.
- No internal FSM beyond the valid bit. Address and write ranges wrap naturally (full 2**ADDR_W index space).

Optional Feature:
- Macro: OPPREP_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding as described under Behaviour.
- Undefined: reads return the pre-write array value. The writer must separate a dependent read by at least one cycle. ZERO_REG behaviour is unchanged.

Decomposition:
- Shared package arm_lp_pkg holds: DATA_W, ADDR_W and IMM_W defaults; ZERO_REG constant; an operand bundle struct (valid, op1, op2, offset) reused by the ALU stage.
- One sub-module: regfile_2r1w (array, write enable, ZERO_REG masking, bypass under the macro).
- operand_prep_stage instantiates regfile_2r1w and contains the extension, the mux and the pipeline register.

Test Plan:
- Reset: hold reset 2 cycles, then read all 32 registers with inValid = 1 → outValid 0 during reset, then every readData1/readData2 = 0x00000000.
- Write/read: write R5 = 0xDEADBEEF, next cycle reg1 = 5, aluSRC = 0, inValid = 1 → one cycle later readData1 = 0xDEADBEEF, outValid = 1.
- Zero register: write R31 = 0x12345678, then read reg1 = reg2 = 31 → both operands 0.
- Bypass: same cycle write R7 = 0xA5A5A5A5 and read reg2 = 7, aluSRC = 0 → readData2 = 0xA5A5A5A5 with the macro defined; old value (0) without it.
- Extension and mux: pcOffsetOrig = 26'h3FFFFFC, aluSRC = 1.
  - immSigned = 1 → readData2 = pcOffsetFilled = 0xFFFFFFFC.
  - immSigned = 0 → 0x03FFFFFC.
- Stall and reset mid-stall: capture a valid set, raise stall 3 cycles while changing inputs → outputs unchanged. Then assert reset with stall still high → all outputs 0 next cycle.
